// File: rtl/irrigation_pkg.sv
// Shared types and constants for the irrigation countdown timer.
// Build option IRRIG_PAUSE_EN adds the PAUSED state.
package irrigation_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] UNITS_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] TENS_MAX  = 4'd5;

    typedef enum logic [2:0] {
        IDLE,
        LOADED,
        RUNNING,
`ifdef IRRIG_PAUSE_EN
        DONE,
        PAUSED
`else
        DONE
`endif
    } state_t;

    // Bad BCD digits saturate first, then the whole minute value saturates at max_min.
    function automatic logic [2*DIGIT_W-1:0] clamp_preset(
        input logic [DIGIT_W-1:0] mt,
        input logic [DIGIT_W-1:0] mu,
        input int                 max_min
    );
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] units;
        int                 minutes;
        tens    = (mt > TENS_MAX)  ? TENS_MAX  : mt;
        units   = (mu > UNITS_MAX) ? UNITS_MAX : mu;
        minutes = 10 * int'(tens) + int'(units);
        if (minutes > max_min) begin
            tens  = DIGIT_W'(max_min / 10);
            units = DIGIT_W'(max_min % 10);
        end
        return {tens, units};
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit counting down modulo LIMIT+1, with synchronous clear, load and
// a borrow-out that fires when an enabled decrement wraps the digit.
module bcd_down_digit
    import irrigation_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] LIMIT = UNITS_MAX
) (
    input  logic               clk,
    input  logic               clear_n,
    input  logic               clr,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               en,
    output logic [DIGIT_W-1:0] value,
    output logic               borrow_out
);

    logic [DIGIT_W-1:0] value_reg;
    logic [DIGIT_W-1:0] value_next;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            value_reg <= '0;
        end else begin
            value_reg <= value_next;
        end
    end

    always_comb begin
        value_next = value_reg;
        if (clr) begin
            value_next = '0;
        end else if (load) begin
            value_next = (load_val > LIMIT) ? LIMIT : load_val;
        end else if (en) begin
            value_next = (value_reg == '0) ? LIMIT : value_reg - 1'b1;
        end
    end

    assign value      = value_reg;
    assign borrow_out = en && (value_reg == '0);

endmodule

// File: rtl/irrigation_countdown.sv
// MM:SS irrigation countdown timer driving a valve, built from four cascaded BCD digits.
// Build option IRRIG_PAUSE_EN adds a pause input and a PAUSED state.
module irrigation_countdown
    import irrigation_pkg::*;
#(
    parameter int MAX_MIN = 59
) (
    input  logic               clk,
    input  logic               clear_n,
    input  logic               tick,
    input  logic               load,
    input  logic [DIGIT_W-1:0] preset_mt,
    input  logic [DIGIT_W-1:0] preset_mu,
    input  logic               start,
    input  logic               abort,
`ifdef IRRIG_PAUSE_EN
    input  logic               pause,
`endif
    output logic [DIGIT_W-1:0] min_t,
    output logic [DIGIT_W-1:0] min_u,
    output logic [DIGIT_W-1:0] sec_t,
    output logic [DIGIT_W-1:0] sec_u,
    output logic               valve_on,
    output logic               done
);

    state_t state_reg;
    state_t state_next;
    logic   valve_on_reg;
    logic   done_reg;

    logic                   dec;
    logic                   load_cnt;
    logic                   clr_cnt;
    logic                   count_zero;
    logic                   count_one;
    logic                   count_underflow;
    logic [2*DIGIT_W-1:0]   preset_clamped;
    logic [4*DIGIT_W-1:0]   load_word;
    logic [4*DIGIT_W-1:0]   count_word;

    assign preset_clamped = clamp_preset(preset_mt, preset_mu, MAX_MIN);
    assign load_word      = {preset_clamped, {(2*DIGIT_W){1'b0}}};

    // Digit 0 is sec_u; odd digits are tens (mod 6), even digits are units (mod 10).
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            localparam logic [DIGIT_W-1:0] LIMIT = (gi % 2 == 1) ? TENS_MAX : UNITS_MAX;
            logic               en_in;
            logic               borrow_out;
            logic [DIGIT_W-1:0] value;

            if (gi == 0) begin : g_first
                assign en_in = dec;
            end else begin : g_chain
                assign en_in = g_digit[gi-1].borrow_out;
            end

            bcd_down_digit #(
                .LIMIT (LIMIT)
            ) u_digit (
                .clk        (clk),
                .clear_n    (clear_n),
                .clr        (clr_cnt),
                .load       (load_cnt),
                .load_val   (load_word[gi*DIGIT_W +: DIGIT_W]),
                .en         (en_in),
                .value      (value),
                .borrow_out (borrow_out)
            );

            assign count_word[gi*DIGIT_W +: DIGIT_W] = value;
        end
    endgenerate

    // A borrow out of the top digit would mean decrementing past 00:00.
    assign count_underflow = g_digit[3].borrow_out;
    assign count_zero      = (count_word == '0);
    assign count_one       = (count_word == {{(4*DIGIT_W-1){1'b0}}, 1'b1});

    always_comb begin
        dec = (state_reg == RUNNING) && tick && !abort;
`ifdef IRRIG_PAUSE_EN
        if (pause) begin
            dec = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_reg    <= IDLE;
            valve_on_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            valve_on_reg <= (state_next == RUNNING);
            done_reg     <= (state_next == DONE) && (state_reg != DONE);
        end
    end

    always_comb begin
        state_next = state_reg;
        load_cnt   = 1'b0;
        clr_cnt    = 1'b0;
        if (abort) begin
            state_next = IDLE;
            clr_cnt    = 1'b1;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (load) begin
                        load_cnt   = 1'b1;
                        state_next = LOADED;
                    end
                end
                LOADED: begin
                    if (start) begin
                        state_next = count_zero ? DONE : RUNNING;
                    end
                end
                RUNNING: begin
`ifdef IRRIG_PAUSE_EN
                    if (pause) begin
                        state_next = PAUSED;
                    end else
`endif
                    if (tick) begin
                        if (count_one || count_underflow) begin
                            state_next = DONE;
                        end
                        if (count_underflow) begin
                            clr_cnt = 1'b1;
                        end
                    end
                end
`ifdef IRRIG_PAUSE_EN
                PAUSED: begin
                    if (start) begin
                        state_next = RUNNING;
                    end
                end
`endif
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign min_t    = count_word[4*DIGIT_W-1:3*DIGIT_W];
    assign min_u    = count_word[3*DIGIT_W-1:2*DIGIT_W];
    assign sec_t    = count_word[2*DIGIT_W-1:DIGIT_W];
    assign sec_u    = count_word[DIGIT_W-1:0];
    assign valve_on = valve_on_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_irrigation_countdown.sv
// Bench for irrigation_countdown: vector table, corner-case sequences and random
// stimulus, all compared against a seconds-based reference model.
module tb_irrigation_countdown;

    localparam int MAX_MIN = 59;
    localparam int M_IDLE = 0, M_LOADED = 1, M_RUN = 2, M_DONE = 3;

    logic       clk = 1'b0;
    logic       clear_n;
    logic       tick, load, start, abort;
    logic [3:0] preset_mt, preset_mu;
`ifdef IRRIG_PAUSE_EN
    logic       pause = 1'b0;
`endif
    logic [3:0] min_t, min_u, sec_t, sec_u;
    logic       valve_on, done;
    logic [15:0] dut_count;

    int   m_st, m_secs;
    logic m_valve, m_done;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   valve_ticks, done_cnt;

    typedef struct {
        logic        t, l, s, a;
        logic [3:0]  mt, mu;
        logic [15:0] exp_cnt;
        logic        exp_valve, exp_done;
    } vec_t;
    vec_t vecs[22];

    irrigation_countdown #(.MAX_MIN(MAX_MIN)) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .tick      (tick),
        .load      (load),
        .preset_mt (preset_mt),
        .preset_mu (preset_mu),
        .start     (start),
        .abort     (abort),
`ifdef IRRIG_PAUSE_EN
        .pause     (pause),
`endif
        .min_t     (min_t),
        .min_u     (min_u),
        .sec_t     (sec_t),
        .sec_u     (sec_u),
        .valve_on  (valve_on),
        .done      (done)
    );

    assign dut_count = {min_t, min_u, sec_t, sec_u};

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] to_bcd(input int secs);
        int mm, ss;
        mm = secs / 60;
        ss = secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic int preset_minutes(input logic [3:0] mt, input logic [3:0] mu);
        int t, u, m;
        t = (mt > 4'd5) ? 5 : int'(mt);
        u = (mu > 4'd9) ? 9 : int'(mu);
        m = t * 10 + u;
        return (m > MAX_MIN) ? MAX_MIN : m;
    endfunction

    function automatic vec_t mk(input logic t, l, s, a, input logic [3:0] mt, mu,
                                input logic [15:0] c, input logic v, d);
        vec_t r;
        r.t = t; r.l = l; r.s = s; r.a = a; r.mt = mt; r.mu = mu;
        r.exp_cnt = c; r.exp_valve = v; r.exp_done = d;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_secs = 0; m_valve = 1'b0; m_done = 1'b0;
    endtask

    // Reference behaviour for one clock edge, using the inputs applied for it.
    task automatic model_edge();
        m_done = 1'b0;
        if (abort) begin
            m_st = M_IDLE; m_secs = 0;
        end else if ((m_st == M_IDLE || m_st == M_DONE) && load) begin
            m_secs = preset_minutes(preset_mt, preset_mu) * 60;
            m_st   = M_LOADED;
        end else if (m_st == M_LOADED && start) begin
            if (m_secs == 0) begin
                m_st = M_DONE; m_done = 1'b1;
            end else begin
                m_st = M_RUN;
            end
        end else if (m_st == M_RUN && tick) begin
            m_secs = m_secs - 1;
            if (m_secs == 0) begin
                m_st = M_DONE; m_done = 1'b1;
            end
        end
        m_valve = (m_st == M_RUN);
    endtask

    task automatic step(input logic t, l, s, a, input logic [3:0] mt, mu);
        @(negedge clk);
        tick = t; load = l; start = s; abort = a; preset_mt = mt; preset_mu = mu;
        @(posedge clk);
        model_edge();
        #1;
        check("model_count", {16'h0, dut_count}, {16'h0, to_bcd(m_secs)});
        check("model_valve", valve_on, m_valve);
        check("model_done",  done,     m_done);
    endtask

    initial begin
        vecs[0]  = mk(0,1,0,0, 4'h0,4'h2, 16'h0200, 0, 0);
        vecs[1]  = mk(0,0,1,0, 4'h0,4'h0, 16'h0200, 1, 0);
        vecs[2]  = mk(1,0,0,0, 4'h0,4'h0, 16'h0159, 1, 0);
        vecs[3]  = mk(1,0,0,0, 4'h0,4'h0, 16'h0158, 1, 0);
        vecs[4]  = mk(0,1,0,0, 4'h5,4'h0, 16'h0158, 1, 0);
        vecs[5]  = mk(1,0,1,0, 4'h0,4'h0, 16'h0157, 1, 0);
        vecs[6]  = mk(1,0,0,1, 4'h0,4'h0, 16'h0000, 0, 0);
        vecs[7]  = mk(1,0,0,0, 4'h0,4'h0, 16'h0000, 0, 0);
        vecs[8]  = mk(0,0,1,0, 4'h0,4'h0, 16'h0000, 0, 0);
        vecs[9]  = mk(0,1,0,0, 4'h7,4'hC, 16'h5900, 0, 0);
        vecs[10] = mk(0,1,0,0, 4'h3,4'h3, 16'h5900, 0, 0);
        vecs[11] = mk(1,0,0,0, 4'h0,4'h0, 16'h5900, 0, 0);
        vecs[12] = mk(0,0,0,1, 4'h0,4'h0, 16'h0000, 0, 0);
        vecs[13] = mk(0,1,0,0, 4'h0,4'h0, 16'h0000, 0, 0);
        vecs[14] = mk(0,0,1,0, 4'h0,4'h0, 16'h0000, 0, 1);
        vecs[15] = mk(0,0,0,0, 4'h0,4'h0, 16'h0000, 0, 0);
        vecs[16] = mk(0,1,0,0, 4'h1,4'h5, 16'h1500, 0, 0);
        vecs[17] = mk(1,1,1,1, 4'h0,4'h9, 16'h0000, 0, 0);
        vecs[18] = mk(0,1,0,0, 4'h6,4'h3, 16'h5300, 0, 0);
        vecs[19] = mk(0,0,0,1, 4'h0,4'h0, 16'h0000, 0, 0);
        vecs[20] = mk(0,1,0,0, 4'h2,4'hF, 16'h2900, 0, 0);
        vecs[21] = mk(0,0,0,1, 4'h0,4'h0, 16'h0000, 0, 0);

        tick = 0; load = 0; start = 0; abort = 0; preset_mt = 0; preset_mu = 0;
        clear_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_count", {16'h0, dut_count}, 32'h0);
        check("reset_valve", valve_on, 1'b0);
        check("reset_done",  done,     1'b0);
        @(negedge clk);
        clear_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            step(vecs[i].t, vecs[i].l, vecs[i].s, vecs[i].a, vecs[i].mt, vecs[i].mu);
            check($sformatf("vec%0d_count", i), {16'h0, dut_count}, {16'h0, vecs[i].exp_cnt});
            check($sformatf("vec%0d_valve", i), valve_on, vecs[i].exp_valve);
            check($sformatf("vec%0d_done", i),  done,     vecs[i].exp_done);
        end

        // One minute: 60 ticks, one done pulse, valve high for every tick.
        step(0,1,0,0, 4'h0,4'h1);
        check("one_min_loaded", {16'h0, dut_count}, 32'h0100);
        step(0,0,1,0, 4'h0,4'h0);
        valve_ticks = 0; done_cnt = 0;
        for (int i = 1; i <= 63; i++) begin
            if (valve_on) valve_ticks++;
            step(1,0,0,0, 4'h0,4'h0);
            if (done) done_cnt++;
            if (i == 1)  check("one_min_first_tick", {16'h0, dut_count}, 32'h0059);
            if (i == 60) check("one_min_expired", {16'h0, dut_count}, 32'h0000);
            step(0,0,0,0, 4'h0,4'h0);
            if (done) done_cnt++;
        end
        check("one_min_valve_ticks", valve_ticks, 60);
        check("one_min_done_pulses", done_cnt, 1);

        // Ten minutes: minute borrow, then run out and hold at zero.
        step(0,1,0,0, 4'h1,4'h0);
        step(0,0,1,0, 4'h0,4'h0);
        step(1,0,0,0, 4'h0,4'h0);
        check("ten_min_first_tick", {16'h0, dut_count}, 32'h0959);
        done_cnt = 0;
        for (int i = 2; i <= 600; i++) begin
            step(1,0,0,0, 4'h0,4'h0);
            if (done) done_cnt++;
        end
        check("ten_min_expired", {16'h0, dut_count}, 32'h0000);
        check("ten_min_done_pulses", done_cnt, 1);
        for (int i = 0; i < 5; i++) begin
            step(1,0,0,0, 4'h0,4'h0);
            check("ten_min_hold", {16'h0, dut_count}, 32'h0000);
            check("ten_min_hold_valve", valve_on, 1'b0);
        end

        // Abort colliding with a tick at 00:30.
        step(0,1,0,0, 4'h0,4'h1);
        step(0,0,1,0, 4'h0,4'h0);
        for (int i = 0; i < 30; i++) step(1,0,0,0, 4'h0,4'h0);
        check("abort_pre_count", {16'h0, dut_count}, 32'h0030);
        step(1,0,0,1, 4'h0,4'h0);
        check("abort_count", {16'h0, dut_count}, 32'h0000);
        check("abort_valve", valve_on, 1'b0);
        check("abort_done",  done,     1'b0);
        step(0,0,1,0, 4'h0,4'h0);
        check("abort_idle_start_ignored", valve_on, 1'b0);

        // Asynchronous clear in the middle of a countdown at 03:17.
        step(0,1,0,0, 4'h0,4'h4);
        step(0,0,1,0, 4'h0,4'h0);
        for (int i = 0; i < 43; i++) step(1,0,0,0, 4'h0,4'h0);
        check("clr_pre_count", {16'h0, dut_count}, 32'h0317);
        #2;
        clear_n = 1'b0;
        #1;
        check("clr_count", {16'h0, dut_count}, 32'h0000);
        check("clr_valve", valve_on, 1'b0);
        check("clr_done",  done,     1'b0);
        model_reset();
        @(negedge clk);
        clear_n = 1'b1;
        step(0,1,0,0, 4'h0,4'h2);
        check("clr_reload", {16'h0, dut_count}, 32'h0200);
        step(0,0,1,0, 4'h0,4'h0);
        step(1,0,0,0, 4'h0,4'h0);
        check("clr_resume", {16'h0, dut_count}, 32'h0159);

        // Random traffic, biased toward short presets so expiries happen.
        for (int i = 0; i < 4000; i++) begin
            logic       rt, rl, rs, ra;
            logic [3:0] rmt, rmu;
            rt  = ($urandom_range(0, 1) == 0);
            rl  = ($urandom_range(0, 7) == 0);
            rs  = ($urandom_range(0, 5) == 0);
            ra  = ($urandom_range(0, 249) == 0);
            rmt = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            rmu = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
            step(rt, rl, rs, ra, rmt, rmu);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
